// File: rtl/pzcorebus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pzcorebus_pkg
// Description : Bus profile type, packed-beat width helpers and the skid
//               buffer state encoding shared by the corebus slice blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pzcorebus_pkg;

  typedef struct packed {
    int id_width;
    int address_width;
    int length_width;
    int data_width;
  } pzcorebus_config;

  localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
    id_width:      4,
    address_width: 16,
    length_width:  4,
    data_width:    16
  };

  localparam int PZCOREBUS_COMMAND_WIDTH  = 2;
  localparam int PZCOREBUS_RESPONSE_WIDTH = 2;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } pzcorebus_skid_state;

  // Packed request: {mcmd, mid, maddr, mlength}
  function automatic int get_request_width(pzcorebus_config cfg);
    return PZCOREBUS_COMMAND_WIDTH + cfg.id_width + cfg.address_width + cfg.length_width;
  endfunction

  // Packed write data: {mdata, mdata_last}
  function automatic int get_data_width(pzcorebus_config cfg);
    return cfg.data_width + 1;
  endfunction

  // Packed response: {sresp, sid, sdata, sresp_last}
  function automatic int get_response_width(pzcorebus_config cfg);
    return PZCOREBUS_RESPONSE_WIDTH + cfg.id_width + cfg.data_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pzcorebus_if.sv
`default_nettype none
// ============================================================================
// Module      : pzcorebus_if
// Description : Corebus command / write-data / response channel bundle with
//               master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface pzcorebus_if
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG = PZCOREBUS_DEFAULT_CONFIG
) ();

  localparam int ID_WIDTH     = BUS_CONFIG.id_width;
  localparam int ADDR_WIDTH   = BUS_CONFIG.address_width;
  localparam int LENGTH_WIDTH = BUS_CONFIG.length_width;
  localparam int DATA_WIDTH   = BUS_CONFIG.data_width;

  logic                                mcmd_valid;
  logic                                scmd_accept;
  logic [PZCOREBUS_COMMAND_WIDTH-1:0]  mcmd;
  logic [ID_WIDTH-1:0]                 mid;
  logic [ADDR_WIDTH-1:0]               maddr;
  logic [LENGTH_WIDTH-1:0]             mlength;

  logic                                mdata_valid;
  logic                                sdata_accept;
  logic [DATA_WIDTH-1:0]               mdata;
  logic                                mdata_last;

  logic                                sresp_valid;
  logic                                mresp_accept;
  logic [PZCOREBUS_RESPONSE_WIDTH-1:0] sresp;
  logic [ID_WIDTH-1:0]                 sid;
  logic [DATA_WIDTH-1:0]               sdata;
  logic                                sresp_last;

  modport master (
    output mcmd_valid, mcmd, mid, maddr, mlength,
    input  scmd_accept,
    output mdata_valid, mdata, mdata_last,
    input  sdata_accept,
    input  sresp_valid, sresp, sid, sdata, sresp_last,
    output mresp_accept
  );

  modport slave (
    input  mcmd_valid, mcmd, mid, maddr, mlength,
    output scmd_accept,
    input  mdata_valid, mdata, mdata_last,
    output sdata_accept,
    output sresp_valid, sresp, sid, sdata, sresp_last,
    input  mresp_accept
  );

endinterface
`default_nettype wire

// File: rtl/pzcorebus_skid_slice_unit.sv
`default_nettype none
// ============================================================================
// Module      : pzcorebus_skid_slice_unit
// Description : Generic 2-entry skid buffer; valid, accept and data all leave
//               from flops. o_full exists only with
//               PZCOREBUS_SKID_SLICE_STALL_COUNT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pzcorebus_skid_slice_unit
  import pzcorebus_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef PZCOREBUS_SKID_SLICE_STALL_COUNT_EN
  output logic             o_full,
`endif
  input  logic             i_valid,
  output logic             o_accept,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_accept,
  output logic [WIDTH-1:0] o_data
);

  pzcorebus_skid_state state_d, state_q;
  logic                valid_d, valid_q;
  logic                accept_d, accept_q;
  logic [WIDTH-1:0]    head_d, head_q;
  logic [WIDTH-1:0]    tail_d, tail_q;
  logic                w_push;
  logic                w_pop;

  assign w_push = i_valid & accept_q;
  assign w_pop  = valid_q & i_accept;

  // head always holds the oldest beat; tail is only occupied in TWO
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      SKID_EMPTY: begin
        if (w_push) begin
          state_d = SKID_ONE;
          head_d  = i_data;
        end
      end
      SKID_ONE: begin
        if (w_push && w_pop) begin
          head_d = i_data;
        end else if (w_push) begin
          state_d = SKID_TWO;
          tail_d  = i_data;
        end else if (w_pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (w_pop) begin
          state_d = SKID_ONE;
          head_d  = tail_q;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
    valid_d  = (state_d != SKID_EMPTY);
    accept_d = (state_d != SKID_TWO);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= SKID_EMPTY;
      valid_q  <= 1'b0;
      accept_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      accept_q <= accept_d;
    end
  end

  always_ff @(posedge i_clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign o_valid  = valid_q;
  assign o_accept = accept_q;
  assign o_data   = head_q;
`ifdef PZCOREBUS_SKID_SLICE_STALL_COUNT_EN
  assign o_full   = (state_q == SKID_TWO);
`endif

endmodule
`default_nettype wire

// File: rtl/pzcorebus_skid_slice.sv
`default_nettype none
// ============================================================================
// Module      : pzcorebus_skid_slice
// Description : Fully registered corebus slice: one skid unit per channel.
//               Define PZCOREBUS_SKID_SLICE_STALL_COUNT_EN to build the
//               saturating full-cycle counter; otherwise o_stall_count is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pzcorebus_skid_slice
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG        = PZCOREBUS_DEFAULT_CONFIG,
  parameter int              STALL_COUNT_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  pzcorebus_if.slave                   slave_if,
  pzcorebus_if.master                  master_if,
  output logic [STALL_COUNT_WIDTH-1:0] o_stall_count
);

  localparam int REQ_WIDTH  = get_request_width(BUS_CONFIG);
  localparam int DATA_WIDTH = get_data_width(BUS_CONFIG);
  localparam int RESP_WIDTH = get_response_width(BUS_CONFIG);

  logic [REQ_WIDTH-1:0]  w_cmd_in, w_cmd_out;
  logic [DATA_WIDTH-1:0] w_data_in, w_data_out;
  logic [RESP_WIDTH-1:0] w_resp_in, w_resp_out;
`ifdef PZCOREBUS_SKID_SLICE_STALL_COUNT_EN
  logic                  w_cmd_full, w_data_full, w_resp_full;
`endif

  // Field order here must match the packing helpers in pzcorebus_pkg
  assign w_cmd_in  = {slave_if.mcmd, slave_if.mid, slave_if.maddr, slave_if.mlength};
  assign w_data_in = {slave_if.mdata, slave_if.mdata_last};
  assign w_resp_in = {master_if.sresp, master_if.sid, master_if.sdata, master_if.sresp_last};

  assign {master_if.mcmd, master_if.mid, master_if.maddr, master_if.mlength} = w_cmd_out;
  assign {master_if.mdata, master_if.mdata_last}                            = w_data_out;
  assign {slave_if.sresp, slave_if.sid, slave_if.sdata, slave_if.sresp_last} = w_resp_out;

  pzcorebus_skid_slice_unit #(
    .WIDTH (REQ_WIDTH)
  ) u_cmd_unit (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
`ifdef PZCOREBUS_SKID_SLICE_STALL_COUNT_EN
    .o_full   (w_cmd_full),
`endif
    .i_valid  (slave_if.mcmd_valid),
    .o_accept (slave_if.scmd_accept),
    .i_data   (w_cmd_in),
    .o_valid  (master_if.mcmd_valid),
    .i_accept (master_if.scmd_accept),
    .o_data   (w_cmd_out)
  );

  pzcorebus_skid_slice_unit #(
    .WIDTH (DATA_WIDTH)
  ) u_data_unit (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
`ifdef PZCOREBUS_SKID_SLICE_STALL_COUNT_EN
    .o_full   (w_data_full),
`endif
    .i_valid  (slave_if.mdata_valid),
    .o_accept (slave_if.sdata_accept),
    .i_data   (w_data_in),
    .o_valid  (master_if.mdata_valid),
    .i_accept (master_if.sdata_accept),
    .o_data   (w_data_out)
  );

  // Response flows downstream-to-upstream
  pzcorebus_skid_slice_unit #(
    .WIDTH (RESP_WIDTH)
  ) u_resp_unit (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
`ifdef PZCOREBUS_SKID_SLICE_STALL_COUNT_EN
    .o_full   (w_resp_full),
`endif
    .i_valid  (master_if.sresp_valid),
    .o_accept (master_if.mresp_accept),
    .i_data   (w_resp_in),
    .o_valid  (slave_if.sresp_valid),
    .i_accept (slave_if.mresp_accept),
    .o_data   (w_resp_out)
  );

`ifdef PZCOREBUS_SKID_SLICE_STALL_COUNT_EN
  logic                         w_any_full;
  logic [STALL_COUNT_WIDTH-1:0] stall_count_d, stall_count_q;

  assign w_any_full = w_cmd_full | w_data_full | w_resp_full;

  always_comb begin
    stall_count_d = stall_count_q;
    if (w_any_full && (stall_count_q != {STALL_COUNT_WIDTH{1'b1}})) begin
      stall_count_d = stall_count_q + STALL_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign o_stall_count = stall_count_q;
`else
  assign o_stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pzcorebus_skid_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_pzcorebus_skid_slice
// Description : Directed and randomized checks of pzcorebus_skid_slice
//               against a queue-based channel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pzcorebus_skid_slice;
  import pzcorebus_pkg::*;

  localparam int SCW   = 4;
  localparam int SMAX  = (1 << SCW) - 1;
  localparam int REQ_W = 26;
  localparam int DAT_W = 17;
  localparam int RSP_W = 23;
`ifdef PZCOREBUS_SKID_SLICE_STALL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [SCW-1:0] stall;

  int n_checks = 0;
  int n_errors = 0;

  pzcorebus_if #(.BUS_CONFIG(PZCOREBUS_DEFAULT_CONFIG)) up ();
  pzcorebus_if #(.BUS_CONFIG(PZCOREBUS_DEFAULT_CONFIG)) dn ();

  pzcorebus_skid_slice #(
    .BUS_CONFIG        (PZCOREBUS_DEFAULT_CONFIG),
    .STALL_COUNT_WIDTH (SCW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .slave_if      (up),
    .master_if     (dn),
    .o_stall_count (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one FIFO of depth 2 per channel
  logic [REQ_W-1:0] cq[$];
  logic [DAT_W-1:0] dq[$];
  logic [RSP_W-1:0] rq[$];
  int  mcount   = 0;
  bit  model_ok = 1'b0;

  task automatic model_step();
    bit full, pu, po;
    if (rst) begin
      cq.delete(); dq.delete(); rq.delete();
      mcount   = 0;
      model_ok = 1'b1;
      return;
    end
    full = (cq.size() == 2) || (dq.size() == 2) || (rq.size() == 2);
    if (CNT_EN && full && mcount < SMAX) mcount++;
    pu = up.mcmd_valid && (cq.size() < 2);
    po = (cq.size() > 0) && dn.scmd_accept;
    if (po) void'(cq.pop_front());
    if (pu) cq.push_back({up.mcmd, up.mid, up.maddr, up.mlength});
    pu = up.mdata_valid && (dq.size() < 2);
    po = (dq.size() > 0) && dn.sdata_accept;
    if (po) void'(dq.pop_front());
    if (pu) dq.push_back({up.mdata, up.mdata_last});
    pu = dn.sresp_valid && (rq.size() < 2);
    po = (rq.size() > 0) && up.mresp_accept;
    if (po) void'(rq.pop_front());
    if (pu) rq.push_back({dn.sresp, dn.sid, dn.sdata, dn.sresp_last});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmd_valid", dn.mcmd_valid, cq.size() != 0);
      if (cq.size() != 0) chk("cmd_payload", {dn.mcmd, dn.mid, dn.maddr, dn.mlength}, cq[0]);
      chk("cmd_accept", up.scmd_accept, cq.size() < 2);
      chk("data_valid", dn.mdata_valid, dq.size() != 0);
      if (dq.size() != 0) chk("data_payload", {dn.mdata, dn.mdata_last}, dq[0]);
      chk("data_accept", up.sdata_accept, dq.size() < 2);
      chk("resp_valid", up.sresp_valid, rq.size() != 0);
      if (rq.size() != 0) chk("resp_payload", {up.sresp, up.sid, up.sdata, up.sresp_last}, rq[0]);
      chk("resp_accept", dn.mresp_accept, rq.size() < 2);
      chk("stall_count", stall, mcount);
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    up.mcmd_valid = 1'b0; up.mdata_valid = 1'b0; dn.sresp_valid = 1'b0;
    dn.scmd_accept = 1'b1; dn.sdata_accept = 1'b1; up.mresp_accept = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_cmd(input logic [15:0] addr);
    up.mcmd = 2'd1; up.mid = addr[3:0]; up.maddr = addr; up.mlength = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    up.mcmd = '0; up.mid = '0; up.maddr = '0; up.mlength = '0;
    up.mdata = '0; up.mdata_last = 1'b0;
    dn.sresp = '0; dn.sid = '0; dn.sdata = '0; dn.sresp_last = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mcmd_valid", dn.mcmd_valid, 0);
    chk("rst_scmd_accept", up.scmd_accept, 1);
    chk("rst_sdata_accept", up.sdata_accept, 1);
    chk("rst_mresp_accept", dn.mresp_accept, 1);
    chk("rst_sresp_valid", up.sresp_valid, 0);
    chk("rst_stall", stall, 0);

    // Single command beat, one-cycle latency
    step();
    up.mcmd_valid = 1'b1; set_cmd(16'h0100);
    @(negedge clk); chk("c027_pre_valid", dn.mcmd_valid, 0);
    step(); up.mcmd_valid = 1'b0;
    @(negedge clk); chk("c027_valid", dn.mcmd_valid, 1); chk("c027_addr", dn.maddr, 32'h100);
    step();
    @(negedge clk); chk("c027_after", dn.mcmd_valid, 0);
    step();

    // 16 back-to-back data beats
    for (int i = 0; i < 16; i++) begin
      up.mdata_valid = 1'b1; up.mdata = i[15:0]; up.mdata_last = (i == 15);
      @(negedge clk);
      chk("c028_sdata_accept", up.sdata_accept, 1);
      chk("c028_scmd_accept", up.scmd_accept, 1);
      if (i > 0) begin
        chk("c028_valid", dn.mdata_valid, 1);
        chk("c028_beat", dn.mdata, i - 1);
      end
      step();
    end
    up.mdata_valid = 1'b0;
    @(negedge clk); chk("c028_last_beat", dn.mdata, 15); chk("c028_last_flag", dn.mdata_last, 1);
    step();
    @(negedge clk); chk("c028_drained", dn.mdata_valid, 0);

    // Backpressure: A and B held, C refused until release
    do_reset();
    dn.scmd_accept = 1'b0;
    up.mcmd_valid = 1'b1; set_cmd(16'h0A0A);
    step();
    set_cmd(16'h0B0B);
    @(negedge clk); chk("c029_accept_one", up.scmd_accept, 1); chk("c029_out_a0", dn.maddr, 32'hA0A);
    step();
    set_cmd(16'h0C0C);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("c029_accept_two", up.scmd_accept, 0); chk("c029_hold_a", dn.maddr, 32'hA0A);
      step();
    end
    dn.scmd_accept = 1'b1;
    @(negedge clk); chk("c029_out_a", dn.maddr, 32'hA0A);
    step();
    @(negedge clk); chk("c029_out_b", dn.maddr, 32'hB0B); chk("c029_accept_rel", up.scmd_accept, 1);
    step();
    up.mcmd_valid = 1'b0;
    @(negedge clk); chk("c029_out_c", dn.maddr, 32'hC0C); chk("c029_stall", stall, CNT_EN ? 4 : 0);
    step();
    @(negedge clk); chk("c029_drained", dn.mcmd_valid, 0);

    // Response channel held in ONE with push and pop together
    do_reset();
    for (int k = 0; k < 9; k++) begin
      dn.sresp_valid = 1'b1; dn.sresp = 2'd2; dn.sid = k[3:0];
      dn.sdata = 16'h0010 + k[15:0]; dn.sresp_last = (k == 8);
      @(negedge clk);
      chk("c030_accept", dn.mresp_accept, 1);
      if (k > 0) begin
        chk("c030_valid", up.sresp_valid, 1);
        chk("c030_beat", up.sdata, 32'h10 + k - 1);
      end
      step();
    end
    dn.sresp_valid = 1'b0;
    @(negedge clk); chk("c030_last", up.sdata, 32'h18);
    step();
    @(negedge clk); chk("c030_drained", up.sresp_valid, 0);

    // Reset while the command buffer is full
    do_reset();
    dn.scmd_accept = 1'b0;
    up.mcmd_valid = 1'b1; set_cmd(16'h0D0D);
    step();
    set_cmd(16'h0E0E);
    step();
    up.mcmd_valid = 1'b0;
    @(negedge clk); chk("c031_full", up.scmd_accept, 0);
    rst = 1'b1;
    step();
    rst = 1'b0; dn.scmd_accept = 1'b1;
    @(negedge clk); chk("c031_valid", dn.mcmd_valid, 0); chk("c031_accept", up.scmd_accept, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk); chk("c031_no_old", dn.mcmd_valid, 0);
    end

    // Stall counter saturation
    do_reset();
    dn.scmd_accept = 1'b0;
    up.mcmd_valid = 1'b1; set_cmd(16'h0F0F);
    step(); step();
    up.mcmd_valid = 1'b0;
    repeat (14) step();
    @(negedge clk); chk("c032_stall14", stall, CNT_EN ? 14 : 0);
    repeat (6) step();
    @(negedge clk); chk("c032_stall_sat", stall, CNT_EN ? 15 : 0);

    // Randomized traffic on all channels
    do_reset();
    begin
      int pv, pa;
      pv = 50; pa = 50;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 300 == 0) begin
          pv = $urandom_range(20, 100);
          pa = $urandom_range(5, 100);
        end
        rst = ($urandom_range(0, 599) == 0);
        up.mcmd_valid  = ($urandom_range(0, 99) < pv);
        up.mdata_valid = ($urandom_range(0, 99) < pv);
        dn.sresp_valid = ($urandom_range(0, 99) < pv);
        dn.scmd_accept  = ($urandom_range(0, 99) < pa);
        dn.sdata_accept = ($urandom_range(0, 99) < pa);
        up.mresp_accept = ($urandom_range(0, 99) < pa);
        {up.mcmd, up.mid, up.maddr, up.mlength} = REQ_W'($urandom);
        {up.mdata, up.mdata_last} = DAT_W'($urandom);
        {dn.sresp, dn.sid, dn.sdata, dn.sresp_last} = RSP_W'($urandom);
        step();
      end
    end
    rst = 1'b0;
    idle();
    repeat (4) step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pzcorebus_skid_slice.md
PZCOREBUS_SKID_SLICE -- requirements
Module: pzcorebus_skid_slice

Interface
REQ-001 SHALL have parameter BUS_CONFIG, default pzcorebus_config default value, meaning bus profile/widths shared with slave_if/master_if.
REQ-002 SHALL have parameter STALL_COUNT_WIDTH, default 16, meaning width of the stall counter output.
REQ-003 SHALL have port i_clk  input  1  clock; one clock domain only, all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port slave_if  pzcorebus_if.slave  BUS_CONFIG  upstream side: command, data and response channels.
REQ-006 SHALL have port master_if  pzcorebus_if.master  BUS_CONFIG  downstream side: command, data and response channels.
REQ-007 SHALL have port o_stall_count  output  STALL_COUNT_WIDTH  count of cycles in which any channel was full.

Function
REQ-008 SHALL insert an independent 2-entry skid buffer on each of the command (mcmd_valid/scmd_accept + get_request fields), data (mdata_valid/sdata_accept) and response (sresp_valid/mresp_accept + get_response fields) channels.
REQ-009 SHALL drive every forward valid and every backward accept from flops only; no combinational path from input to output on any channel.
REQ-010 SHALL use per-channel states EMPTY, ONE, TWO; EMPTY->ONE on push, ONE->TWO on push without pop, TWO->ONE on pop, ONE->EMPTY on pop without push, ONE->ONE on simultaneous push and pop.
REQ-011 SHALL define push as upstream valid and own accept both 1, and pop as own valid and downstream accept both 1.
REQ-012 SHALL assert accept in EMPTY and ONE, and deassert it in TWO.
REQ-013 SHALL present valid in ONE and TWO, always carrying the oldest entry.
REQ-014 SHALL have 1-cycle latency: a beat pushed in cycle N appears at the output in cycle N+1 when the buffer was EMPTY.
REQ-015 SHALL sustain one beat per cycle per channel when the downstream accept stays 1.
REQ-016 SHALL preserve order and payload bit-exactly; no beat dropped or duplicated.
REQ-017 SHALL handle command and data channels independently; no command/data alignment is imposed.
REQ-018 SHALL keep o_stall_count saturating at all-ones, never wrapping.

Reset
REQ-019 SHALL, on i_rst=1, force all channel states to EMPTY: all valids 0, all accepts 1 from the following cycle, o_stall_count 0.
REQ-020 SHALL, on reset mid-operation, discard buffered beats with no partial output.
REQ-021 SHALL leave payload registers unreset.

Configuration
REQ-022 SHALL, with PZCOREBUS_SKID_SLICE_STALL_COUNT_EN defined, increment o_stall_count by 1 in each cycle where any channel is in TWO.
REQ-023 SHALL, without PZCOREBUS_SKID_SLICE_STALL_COUNT_EN, tie o_stall_count to constant 0 and instantiate no counter flops.

Structure
REQ-024 SHALL take the config type, packed request/response types and get/put helpers from pzcorebus_pkg / pzcorebus_if.
REQ-025 SHALL place the skid state enum (EMPTY/ONE/TWO) in pzcorebus_pkg.
REQ-026 SHALL implement one generic sub-module pzcorebus_skid_slice_unit (parameter WIDTH), instantiated three times (command, data, response).

Verification
REQ-027 SHALL cover: reset, then single command beat addr=0x100 with master accept=1 -> master mcmd_valid=1 exactly one cycle later with addr=0x100, then 0.
REQ-028 SHALL cover: 16 back-to-back data beats 0..15 with accept held 1 -> 16 consecutive output beats 0..15, scmd/sdata accept never 0.
REQ-029 SHALL cover: master scmd_accept held 0, push beats A, B, C -> A and B accepted, slave scmd_accept=0 from the cycle after B; release -> A, B, C in order; stall_count=number of TWO cycles (0 without macro).
REQ-030 SHALL cover: response channel in ONE with simultaneous push and pop for 8 cycles -> state stays ONE, each beat output exactly once in order.
REQ-031 SHALL cover: i_rst pulsed while command buffer in TWO -> next cycle mcmd_valid=0, scmd_accept=1, old beats never appear.
REQ-032 SHALL cover: stall counter preset near all-ones (STALL_COUNT_WIDTH=4, 20 full cycles) -> o_stall_count saturates at 15.
